// File: rtl/color_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// color_sequencer_pkg
// Shared constants for the colour sequencer and the colour FSM it feeds.
//   opcode_t : 2-bit colour select opcode carried on the select bus
//   SEL_*    : opcode values (NP = no pulse / idle, R, B, G)
//   ST_*     : sequencer FSM state encoding
// -----------------------------------------------------------------------------
package color_sequencer_pkg;

    typedef logic [1:0] opcode_t;

    localparam opcode_t SEL_NP = 2'b00;
    localparam opcode_t SEL_R  = 2'b01;
    localparam opcode_t SEL_B  = 2'b10;
    localparam opcode_t SEL_G  = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

endpackage

// File: rtl/color_sequencer_seq_mem.sv
// -----------------------------------------------------------------------------
// seq_mem
// DEPTH-entry program store of (colour, dwell) pairs. Synchronous write,
// two combinational read ports: one returns the dwell of an entry, the other
// the colour of a (possibly different) entry.
//   clk        : clock
//   we         : write enable
//   wr_addr    : entry written
//   wr_color   : colour field written
//   wr_dwell   : dwell field written
//   dwell_addr : entry whose dwell is read on rd_dwell
//   rd_dwell   : dwell of mem[dwell_addr]
//   color_addr : entry whose colour is read on rd_color
//   rd_color   : colour of mem[color_addr]
// -----------------------------------------------------------------------------
module seq_mem
    import color_sequencer_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DWELL_W = 8
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  opcode_t                    wr_color,
    input  logic [DWELL_W-1:0]         wr_dwell,
    input  logic [$clog2(DEPTH)-1:0]   dwell_addr,
    output logic [DWELL_W-1:0]         rd_dwell,
    input  logic [$clog2(DEPTH)-1:0]   color_addr,
    output opcode_t                    rd_color
);

    opcode_t            color_mem [DEPTH];
    logic [DWELL_W-1:0] dwell_mem [DEPTH];

    // NOTE: the storage array has no reset; its contents are only read after
    // being written, so a reset would just cost flops' reset wiring for nothing.
    always_ff @(posedge clk) begin
        if (we) begin
            color_mem[wr_addr] <= wr_color;
            dwell_mem[wr_addr] <= wr_dwell;
        end
    end

    assign rd_dwell = dwell_mem[dwell_addr];
    assign rd_color = color_mem[color_addr];

endmodule

// File: rtl/color_sequencer.sv
// -----------------------------------------------------------------------------
// color_sequencer
// Plays a stored program of (colour, dwell) entries onto the colour FSM's
// select bus: each colour for one cycle, then NP for dwell cycles.
//   clk      : clock, rising edge
//   rst      : synchronous active-low reset
//   wr_en    : append (wr_color, wr_dwell) when wr_ready
//   wr_ready : IDLE and program not full (combinational)
//   clear    : empty the program (IDLE only, wins over wr_en)
//   start    : begin playback from entry 0 (IDLE only)
//   stop     : abort playback; program retained
//   loop     : sampled at end of pass, replay from entry 0
//   select   : registered opcode to the colour FSM
//   busy     : registered, playback in progress
//   done     : one-cycle pulse on normal completion
//   count    : number of stored entries
// -----------------------------------------------------------------------------
module color_sequencer
    import color_sequencer_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DWELL_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  opcode_t                  wr_color,
    input  logic [DWELL_W-1:0]       wr_dwell,
    output logic                     wr_ready,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    output opcode_t                  select,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [1:0]         state;
    logic [AW-1:0]      rd_ptr;
    logic [DWELL_W-1:0] dwell_cnt;

    logic               idle;
    logic               wr_accept;
    logic [CW-1:0]      count_next;
    logic               start_go;
    logic               has_next;
    logic [AW-1:0]      next_ptr;
    logic               advance;
    logic [AW-1:0]      color_addr;
    logic [DWELL_W-1:0] cur_dwell;
    opcode_t            rd_color;
    opcode_t            first_color;

    assign idle      = (state == ST_IDLE);
    assign wr_ready  = idle && (count < DEPTH_C);
    assign wr_accept = wr_en && wr_ready && !clear;

    // Next entry in program order; wraps to 0 so a looping replay needs no
    // extra cycle.
    assign has_next = (CW'(rd_ptr) + CW'(1)) < count;
    assign next_ptr = has_next ? rd_ptr + AW'(1) : '0;

    // In IDLE the colour port looks at entry 0, ready for start.
    assign color_addr = idle ? '0 : next_ptr;

    // A write to entry 0 in the start cycle is not yet in the array, so its
    // colour is forwarded straight from the write port.
    assign first_color = (wr_accept && count == '0) ? wr_color : rd_color;

    // NOTE: every signal in this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        count_next = count;
        if (idle && clear) begin
            count_next = '0;
        end else if (wr_accept) begin
            count_next = count + CW'(1);
        end
        start_go = idle && start && !stop && (count_next != '0);
        advance  = 1'b0;
        if (!stop) begin
            if (state == ST_ISSUE && cur_dwell == '0) begin
                advance = 1'b1;
            end else if (state == ST_HOLD && dwell_cnt == DWELL_W'(1)) begin
                advance = 1'b1;
            end
        end
    end

    seq_mem #(
        .DEPTH   (DEPTH),
        .DWELL_W (DWELL_W)
    ) u_seq_mem (
        .clk        (clk),
        .we         (wr_accept),
        .wr_addr    (count[AW-1:0]),
        .wr_color   (wr_color),
        .wr_dwell   (wr_dwell),
        .dwell_addr (rd_ptr),
        .rd_dwell   (cur_dwell),
        .color_addr (color_addr),
        .rd_color   (rd_color)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            rd_ptr    <= '0;
            dwell_cnt <= '0;
            select    <= SEL_NP;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (idle) begin
                count <= count_next;
                if (start_go) begin
                    state  <= ST_ISSUE;
                    rd_ptr <= '0;
                    select <= first_color;
                    busy   <= 1'b1;
                end
            end else if (stop) begin
                state  <= ST_IDLE;
                select <= SEL_NP;
                busy   <= 1'b0;
            end else if (advance) begin
                if (has_next || loop) begin
                    state  <= ST_ISSUE;
                    rd_ptr <= next_ptr;
                    select <= rd_color;
                end else begin
                    state  <= ST_IDLE;
                    select <= SEL_NP;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                end
            end else begin
                case (state)
                    ST_ISSUE: begin
                        state     <= ST_HOLD;
                        dwell_cnt <= cur_dwell;
                        select    <= SEL_NP;
                    end
                    ST_HOLD: begin
                        dwell_cnt <= dwell_cnt - DWELL_W'(1);
                        select    <= SEL_NP;
                    end
                    default: begin
                        state  <= ST_IDLE;
                        select <= SEL_NP;
                        busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_color_sequencer.sv
// -----------------------------------------------------------------------------
// tb_color_sequencer
// Bench for color_sequencer. Expected select/busy/done per cycle come from a
// program-level model: a pass is the concatenation of (colour, dwell x NP)
// per entry, followed by one done cycle unless looping.
// -----------------------------------------------------------------------------
module tb_color_sequencer;
    import color_sequencer_pkg::*;

    localparam int DEPTH   = 8;
    localparam int DWELL_W = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               wr_en = 1'b0;
    opcode_t            wr_color = SEL_NP;
    logic [DWELL_W-1:0] wr_dwell = '0;
    logic               wr_ready;
    logic               clear = 1'b0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               loop = 1'b0;
    opcode_t            select;
    logic               busy;
    logic               done;
    logic [3:0]         count;

    always #5 clk = ~clk;

    color_sequencer #(
        .DEPTH   (DEPTH),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_color (wr_color),
        .wr_dwell (wr_dwell),
        .wr_ready (wr_ready),
        .clear    (clear),
        .start    (start),
        .stop     (stop),
        .loop     (loop),
        .select   (select),
        .busy     (busy),
        .done     (done),
        .count    (count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Program model
    int m_color [DEPTH];
    int m_dwell [DEPTH];
    int m_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pass_len();
        int p = 0;
        for (int i = 0; i < m_count; i++) p += 1 + m_dwell[i];
        return p;
    endfunction

    // Expected outputs t cycles after the start edge (t = 0 is the first
    // cycle of playback).
    function automatic void exp_at(input int t, input bit lp,
                                   output int sel, output int b, output int d);
        int p   = pass_len();
        int pos;
        sel = 0; b = 0; d = 0;
        if (p == 0) return;
        if (!lp && t >= p) begin
            d = (t == p) ? 1 : 0;
            return;
        end
        pos = t % p;
        b = 1;
        for (int i = 0; i < m_count; i++) begin
            if (pos < 1 + m_dwell[i]) begin
                sel = (pos == 0) ? m_color[i] : 0;
                return;
            end
            pos -= 1 + m_dwell[i];
        end
    endfunction

    task automatic do_write(input int c, input int dw);
        logic [1:0] cb;
        logic [7:0] db;
        cb = c[1:0];
        db = dw[7:0];
        wr_en    = 1'b1;
        wr_color = cb;
        wr_dwell = db;
        check("wr_ready", {31'd0, wr_ready}, (m_count < DEPTH) ? 32'd1 : 32'd0);
        tick();
        wr_en = 1'b0;
        if (m_count < DEPTH) begin
            m_color[m_count] = c;
            m_dwell[m_count] = dw;
            m_count++;
        end
        check("count_after_write", {28'd0, count}, m_count);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_count = 0;
        check("count_after_clear", {28'd0, count}, 0);
    endtask

    // Pulse start (optionally with a same-cycle write) and check ncyc cycles.
    // stop is asserted during cycle stop_at (-1 for never).
    task automatic play(input int ncyc, input bit lp, input int stop_at,
                        input bit with_write, input int wc, input int wd);
        bit stopped = 0;
        int es, eb, ed;
        logic [1:0] cb;
        logic [7:0] db;
        cb = wc[1:0];
        db = wd[7:0];
        loop  = lp;
        start = 1'b1;
        if (with_write) begin
            wr_en    = 1'b1;
            wr_color = cb;
            wr_dwell = db;
        end
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        if (with_write && m_count < DEPTH) begin
            m_color[m_count] = wc;
            m_dwell[m_count] = wd;
            m_count++;
        end
        for (int t = 0; t < ncyc; t++) begin
            if (stopped) begin
                es = 0; eb = 0; ed = 0;
            end else begin
                exp_at(t, lp, es, eb, ed);
            end
            check($sformatf("select@%0d", t), {30'd0, select}, es);
            check($sformatf("busy@%0d", t),   {31'd0, busy},   eb);
            check($sformatf("done@%0d", t),   {31'd0, done},   ed);
            if (t == stop_at) begin
                stop = 1'b1;
                tick();
                stop = 1'b0;
                stopped = 1;
            end else begin
                tick();
            end
        end
        loop = 1'b0;
    endtask

    initial begin
        int n, p;

        // Reset
        rst = 1'b0;
        tick();
        tick();
        check("rst_select", {30'd0, select}, SEL_NP);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_count", {28'd0, count}, 0);
        check("rst_wr_ready", {31'd0, wr_ready}, 1);
        rst = 1'b1;
        tick();

        // Directed program R/2, B/0, G/1: single pass then loop with stop on B
        do_write(SEL_R, 2);
        do_write(SEL_B, 0);
        do_write(SEL_G, 1);
        play(9, 0, -1, 0, 0, 0);
        play(14, 1, 9, 0, 0, 0);
        check("count_kept_after_stop", {28'd0, count}, 3);

        // Fill to DEPTH, drop the overflow write, play, then clear
        do_clear();
        for (int i = 0; i < DEPTH; i++) do_write((i % 3) + 1, i % 3);
        check("full_wr_ready", {31'd0, wr_ready}, 0);
        check("full_count", {28'd0, count}, DEPTH);
        do_write(SEL_R, 5);
        play(pass_len() + 2, 0, -1, 0, 0, 0);
        do_clear();
        play(3, 0, -1, 0, 0, 0);

        // Same-cycle write and start into an empty program
        play(3, 0, -1, 1, SEL_G, 0);

        // Controls ignored in HOLD, then reset mid-HOLD
        do_clear();
        do_write(SEL_R, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("hold_issue_select", {30'd0, select}, SEL_R);
        tick();
        wr_en = 1'b1; wr_color = SEL_B; wr_dwell = 8'd1;
        clear = 1'b1; start = 1'b1;
        check("hold_wr_ready", {31'd0, wr_ready}, 0);
        tick();
        wr_en = 1'b0; clear = 1'b0; start = 1'b0;
        check("hold_count", {28'd0, count}, 1);
        check("hold_select", {30'd0, select}, SEL_NP);
        check("hold_busy", {31'd0, busy}, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        m_count = 0;
        check("midrst_select", {30'd0, select}, SEL_NP);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_done", {31'd0, done}, 0);
        check("midrst_count", {28'd0, count}, 0);

        // start and stop together in IDLE
        do_write(SEL_B, 1);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("startstop_busy", {31'd0, busy}, 0);
        check("startstop_select", {30'd0, select}, SEL_NP);
        tick();
        check("startstop_busy2", {31'd0, busy}, 0);

        // Random programs: single pass, then looped pass with random stop
        for (int r = 0; r < 6; r++) begin
            do_clear();
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) do_write($urandom_range(0, 3), $urandom_range(0, 3));
            p = pass_len();
            play(p + 3, 0, -1, 0, 0, 0);
            play(2 * p + 3, 1, $urandom_range(0, 2 * p), 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
